// File: rtl/mic_level_meter.sv
// Microphone loudness meter: per-window peak magnitude of ADC samples, quantised to
// a 0..16 level with optional one-step-per-window decay, plus a thermometer bar.
module mic_level_meter #(
    parameter int WINDOW   = 4096,
    parameter int MIDPOINT = 2048,
    parameter int HOLD_EN  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic [4:0]  level,
    output logic [15:0] bar,
    output logic        level_valid
);
    localparam int CW = $clog2(WINDOW);

    logic [CW-1:0] win_cnt;
    logic          win_end;
    logic [12:0]   mag13;
    logic [11:0]   mag;
    logic          s1_valid;
    logic          s1_last;
    logic [11:0]   peak_acc;
    logic [11:0]   new_peak;
    logic [4:0]    win_level;
    logic [4:0]    held;
    logic [4:0]    held_next;
    logic [15:0]   bar_next;

    assign win_end = (win_cnt == CW'(WINDOW - 1));

    // Distance from midpoint computed in 13 bits so sample=0 yields 2048 cleanly
    always_comb begin
        if (sample >= 12'(MIDPOINT))
            mag13 = {1'b0, sample} - 13'(MIDPOINT);
        else
            mag13 = 13'(MIDPOINT) - {1'b0, sample};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt  <= '0;
            mag      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= sample_valid;
            s1_last  <= sample_valid && win_end;
            if (sample_valid) begin
                mag     <= 12'(mag13);
                win_cnt <= win_end ? '0 : win_cnt + CW'(1);
            end
        end
    end

    assign new_peak  = (mag > peak_acc) ? mag : peak_acc;
    assign win_level = 5'(new_peak >> 7);

    always_comb begin
        if (HOLD_EN != 0)
            held_next = (win_level >= held) ? win_level : held - 5'd1;
        else
            held_next = win_level;
    end

    always_comb begin
        bar_next = '0;
        for (int i = 0; i < 16; i++)
            bar_next[i] = (5'(i) < held_next);
    end

    // Closing sample folds into the finished window while the accumulator restarts at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak_acc    <= '0;
            held        <= '0;
            level       <= '0;
            bar         <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    peak_acc    <= '0;
                    held        <= held_next;
                    level       <= held_next;
                    bar         <= bar_next;
                    level_valid <= 1'b1;
                end else begin
                    peak_acc <= new_peak;
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_level_meter.sv
// Bench for mic_level_meter: directed windows plus random samples and gaps,
// checked every cycle against a window-level reference model (hold and raw variants).
module tb_mic_level_meter;
    localparam int W = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic [4:0]  level,  level0;
    logic [15:0] bar,    bar0;
    logic        level_valid, level_valid0;

    mic_level_meter #(.WINDOW(W), .MIDPOINT(2048), .HOLD_EN(1)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .level(level), .bar(bar), .level_valid(level_valid));

    mic_level_meter #(.WINDOW(W), .MIDPOINT(2048), .HOLD_EN(0)) dut0 (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .level(level0), .bar(bar0), .level_valid(level_valid0));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model state
    int q[$];
    int held_m, exp_lvl, exp_lvl0;
    bit exp_vld, pend;
    int pend_lvl, pend_lvl0;

    function automatic int therm(input int l);
        return (1 << l) - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " valid"},  32'(level_valid),  32'(exp_vld));
        chk({tag, " level"},  32'(level),        32'(exp_lvl));
        chk({tag, " bar"},    32'(bar),          32'(therm(exp_lvl)));
        chk({tag, " valid0"}, 32'(level_valid0), 32'(exp_vld));
        chk({tag, " level0"}, 32'(level0),       32'(exp_lvl0));
        chk({tag, " bar0"},   32'(bar0),         32'(therm(exp_lvl0)));
    endtask

    // One clock with given inputs; compare outputs, then fold the accepted sample into the model
    task automatic cyc(input bit v, input logic [11:0] s);
        int peak, a, wl;
        sample_valid = v;
        sample       = s;
        @(posedge clock);
        #1;
        exp_vld = pend;
        if (pend) begin
            exp_lvl  = pend_lvl;
            exp_lvl0 = pend_lvl0;
        end
        pend = 0;
        chk_all("cycle");
        if (v) begin
            q.push_back(int'(s));
            if (q.size() == W) begin
                peak = 0;
                foreach (q[i]) begin
                    a = (q[i] >= 2048) ? q[i] - 2048 : 2048 - q[i];
                    if (a > peak) peak = a;
                end
                wl = peak / 128;
                held_m    = (wl >= held_m) ? wl : held_m - 1;
                pend      = 1;
                pend_lvl  = held_m;
                pend_lvl0 = wl;
                q.delete();
            end
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        reset = 1'b1;
        #3;
        q.delete();
        held_m = 0; exp_lvl = 0; exp_lvl0 = 0; exp_vld = 0; pend = 0;
        chk_all("reset");
        #2;
        reset = 1'b0;
    endtask

    task automatic lit(input string tag, input int l, input int l0);
        chk({tag, " lit level"}, 32'(level),  32'(l));
        chk({tag, " lit bar"},   32'(bar),    32'(therm(l)));
        chk({tag, " lit level0"}, 32'(level0), 32'(l0));
    endtask

    task automatic window(input int pos, input logic [11:0] special);
        for (int i = 0; i < W; i++) cyc(1'b1, (i == pos) ? special : 12'd2048);
        cyc(1'b0, 12'd0);
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample = '0;
        held_m = 0; exp_lvl = 0; exp_lvl0 = 0; exp_vld = 0; pend = 0;
        #12;
        chk_all("por");
        reset = 1'b0;

        // reset mid-window leaves no residual peak
        for (int i = 0; i < 5; i++) cyc(1'b1, 12'd0);
        do_reset();
        window(0, 12'd2048);
        lit("midreset", 0, 0);

        // back-to-back window with 4095 as third sample
        window(2, 12'd4095);
        lit("max_pos", 15, 15);

        // full scale then decay one step per window, floored at 0
        window(4, 12'd0);
        lit("full", 16, 16);
        for (int k = 0; k < 18; k++) begin
            window(0, 12'd2048);
            lit("decay", (15 - k > 0) ? 15 - k : 0, 0);
        end

        // raw levels without hold
        window(1, 12'd1024); lit("raw1024", 8, 8);
        window(5, 12'd3072); lit("raw3072", 8, 8);
        window(0, 12'd2048); lit("raw2048", 7, 0);

        // random gaps between 24 strobes
        do_reset();
        for (int i = 0; i < 24; i++) begin
            int gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) cyc(1'b0, 12'($urandom));
            cyc(1'b1, 12'($urandom));
        end
        for (int g = 0; g < 3; g++) cyc(1'b0, 12'd0);

        // boundary sample belongs to the new window
        do_reset();
        for (int i = 0; i < W; i++) cyc(1'b1, 12'd2048);
        cyc(1'b1, 12'd0);
        for (int i = 1; i < W; i++) cyc(1'b1, 12'd2048);
        cyc(1'b0, 12'd0);
        lit("boundary", 16, 16);

        // random soak: varied amplitude, gaps, occasional reset
        for (int n = 0; n < 240; n++) begin
            int amp = 1 << $urandom_range(4, 11);
            int s   = 2048 + $urandom_range(0, 2 * amp) - amp;
            if (s < 0) s = 0;
            if (s > 4095) s = 4095;
            if ($urandom_range(0, 79) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) cyc(1'b0, 12'($urandom));
            cyc(1'b1, 12'(s));
        end
        for (int g = 0; g < 3; g++) cyc(1'b0, 12'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic_level_meter.md
Name: mic_level_meter

Overview:
- Upstream feeder of the soundbar display mux.
- Converts a stream of 12-bit microphone samples into a quantised loudness level (0..16) and a 16-bit thermometer bar.
- The display mux consumes the bar as its 16-bit level input; the bar also drives the board LEDs.
- Peak is measured per fixed sample window, with a one-step-per-window decay hold so the bar falls smoothly.

Parameters:
- WINDOW, 4096, number of valid samples per measurement window (≥2).
- MIDPOINT, 2048, ADC code treated as zero amplitude.
- HOLD_EN, 1, 1 = peak-hold with decay enabled; 0 = raw window level.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sample_valid  in  1  one-cycle strobe marking a new sample (may be high on consecutive cycles).
- sample  in  12  unsigned ADC code, sampled when sample_valid=1.
- level  out  5  displayed level 0..16.
- bar  out  16  thermometer of level: bar[i]=1 iff i < level.
- level_valid  out  1  one-cycle pulse when level/bar update.

Behaviour:
- Reset (async, any time including mid-window):
  - level=0, bar=16'h0000, level_valid=0.
  - Window counter=0, peak accumulator=0, held level=0, pipeline valid flags=0.
  - After reset release, the first accepted sample is sample 1 of a fresh window.
- Stage 1, on the cycle after sample_valid:
  - mag = (sample ≥ MIDPOINT) ? sample−MIDPOINT : MIDPOINT−sample, 12-bit unsigned.
  - Range 0..2048; 2048 only for sample=0.
  - The mag register, s1_valid and s1_last are registered together.
  - s1_last=1 when this sample is the WINDOW-th of the window.
- Window counter:
  - Increments on each sample_valid.
  - Wraps to 0 on the WINDOW-th sample, in the same cycle the sample is tagged s1_last.
- Stage 2, on s1_valid:
  - new_peak = max(peak_acc, mag).
  - If s1_last=0: peak_acc ← new_peak.
  - If s1_last=1: win_level = new_peak[11:7] (0..16) and peak_acc ← 0. The next window starts from 0 with no sample lost, even when sample_valid is high on every cycle.
- Hold/decay (HOLD_EN=1), evaluated at window end:
  - held ← (win_level ≥ held) ? win_level : held−1.
  - held never goes below 0.
  - With HOLD_EN=0: held ← win_level.
- Outputs:
  - Registered; update in the same cycle as stage 2 processes s1_last, i.e. two clocks after the sample_valid of the WINDOW-th sample.
  - level ← held, bar ← thermometer(held), level_valid=1 for exactly that cycle.
  - Values are held otherwise.
- Thermometer examples: 0→16'h0000, 1→16'h0001, 8→16'h00FF, 15→16'h7FFF, 16→16'hFFFF.
- Gaps: sample_valid may have arbitrary gaps; the window is counted in samples, not cycles.
- Boundary cases:
  - sample=MIDPOINT gives mag 0.
  - sample=4095 gives mag 2047 → level 15.
  - sample=0 gives 2048 → level 16.
  - No arithmetic overflow: the mag subtraction is performed in 13 bits and truncated after the range check.
- Idle: no output change without sample_valid.

Test Plan (WINDOW=8 unless stated):
- Reset mid-window after 5 samples of 0 → level=0, bar=0; next 8 samples of 2048 → level_valid pulse with level=0, bar=16'h0000 (no leftover peak).
- 8 back-to-back samples (sample_valid held high), the 3rd =4095, rest =2048 → level_valid exactly 2 clocks after the 8th strobe; level=15, bar=16'h7FFF.
- One window containing sample=0 → level=16, bar=16'hFFFF; following window all 2048 with HOLD_EN=1 → level=15, bar=16'h7FFF; then 14, 13, … down to 0 over successive windows, never negative.
- HOLD_EN=0: window peaks 1024→3072→2048 (mags 1024, 1024, 0) → levels 8, 8, 0; bars 16'h00FF, 16'h00FF, 16'h0000.
- Random gaps of 0–5 idle cycles between 24 strobes → exactly 3 level_valid pulses, each 2 clocks after strobes 8, 16, 24; no pulses otherwise.
- Back-to-back window boundary: sample 8 of window 1 =2048, sample 1 of window 2 =0 on the very next cycle, rest 2048 → window 1 level=0, window 2 level=16 (the boundary sample is attributed to the new window).
